// File: rtl/uart_pkg.sv
// Shared constants for the APB UART controller: register map, STATUS/CTRL bit
// positions and the APB handshake state encoding.
package uart_pkg;

  localparam int unsigned ADDR_DATA    = 'h00;
  localparam int unsigned ADDR_DIV_LO  = 'h01;
  localparam int unsigned ADDR_DIV_HI  = 'h02;
  localparam int unsigned ADDR_STATUS  = 'h03;
  localparam int unsigned ADDR_CTRL    = 'h04;
  localparam int unsigned ADDR_INT_CLR = 'h05;

  localparam int unsigned ST_RX_EMPTY = 0;
  localparam int unsigned ST_RX_FULL  = 1;
  localparam int unsigned ST_TX_EMPTY = 2;
  localparam int unsigned ST_TX_FULL  = 3;
  localparam int unsigned ST_RX_OVF   = 4;
  localparam int unsigned ST_TX_BUSY  = 5;

  localparam int unsigned CTRL_TX_EN = 0;
  localparam int unsigned CTRL_RX_IE = 1;
  localparam int unsigned CTRL_TX_IE = 2;

  localparam int unsigned INT_CLR_RX_OVF = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StFetch,
    StResp
  } apb_state_e;

endpackage

// File: rtl/uart_tx_sched.sv
// Transmit sequencer: launches one frame whenever enabled, idle and data is
// queued, then waits for the transmitter's frame-complete pulse.
module uart_tx_sched (
  input  logic clk,
  input  logic rst,
  input  logic i_tx_en,
  input  logic i_ff_empty,
  input  logic i_tx_done,
  output logic o_tx_start,
  output logic o_tx_busy
);

  logic r_start;
  logic r_busy;

  // Busy rises together with the start pulse, so a start can never repeat
  // mid-frame; tx_en is only consulted when idle, so clearing it never aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (r_busy) begin
        if (i_tx_done) r_busy <= 1'b0;
      end else if (i_tx_en && !i_ff_empty) begin
        r_start <= 1'b1;
        r_busy  <= 1'b1;
      end
    end
  end

  assign o_tx_start = r_start;
  assign o_tx_busy  = r_busy;

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB register front-end for a FIFO-based UART: data/divisor/status/control
// registers, RX overflow tracking and a level interrupt.
module uart_apb_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned D_W     = 8,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned AW      = 8,
  parameter int unsigned DIV_RST = 54
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    PADDR,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [D_W-1:0]   PWDATA,
  output logic             PREADY,
  output logic [D_W-1:0]   PRDATA,
  output logic             PSLVERR,
  output logic             rx_ff_rd_en,
  input  logic [D_W-1:0]   rx_ff_data,
  input  logic             rx_ff_empty,
  input  logic             rx_ff_full,
  input  logic             rx_ff_wr_en,
  output logic             tx_ff_wr_en,
  output logic [D_W-1:0]   tx_ff_data,
  input  logic             tx_ff_empty,
  input  logic             tx_ff_full,
  output logic             tx_start,
  input  logic             tx_done,
  output logic [DIV_W-1:0] divxr,
  output logic             irq
);

  apb_state_e     r_state;
  logic [AW-1:0]  r_addr;
  logic           r_write;
  logic [D_W-1:0] r_wdata;
  logic [15:0]    r_div;
  logic [2:0]     r_ctrl;
  logic           r_rx_ovf;
  logic           r_irq;
  logic           r_pready;
  logic           r_pslverr;
  logic [D_W-1:0] r_prdata;
  logic           r_tx_wr_en;
  logic [D_W-1:0] r_tx_data;

  logic           w_tx_busy;
  logic           w_is_data, w_is_div_lo, w_is_div_hi, w_is_status, w_is_ctrl, w_is_int_clr;
  logic           w_unmapped, w_err, w_do_write, w_pop, w_clr_ovf;
  logic [D_W-1:0] w_status;
  logic [D_W-1:0] w_rd_val;

  assign w_is_data    = (r_addr == AW'(ADDR_DATA));
  assign w_is_div_lo  = (r_addr == AW'(ADDR_DIV_LO));
  assign w_is_div_hi  = (r_addr == AW'(ADDR_DIV_HI));
  assign w_is_status  = (r_addr == AW'(ADDR_STATUS));
  assign w_is_ctrl    = (r_addr == AW'(ADDR_CTRL));
  assign w_is_int_clr = (r_addr == AW'(ADDR_INT_CLR));
  assign w_unmapped   = (r_addr > AW'(ADDR_INT_CLR));

  assign w_err = (r_write && w_is_data && tx_ff_full) || (!r_write && w_is_data && rx_ff_empty) ||
                 (r_write && w_is_status) || w_unmapped;
  assign w_do_write = r_write && !w_err;
  assign w_pop      = (r_state == StDecode) && !r_write && w_is_data && !rx_ff_empty;
  assign w_clr_ovf  = (r_state == StDecode) && w_do_write && w_is_int_clr &&
                      r_wdata[INT_CLR_RX_OVF];

  always_comb begin
    w_status              = '0;
    w_status[ST_RX_EMPTY] = rx_ff_empty;
    w_status[ST_RX_FULL]  = rx_ff_full;
    w_status[ST_TX_EMPTY] = tx_ff_empty;
    w_status[ST_TX_FULL]  = tx_ff_full;
    w_status[ST_RX_OVF]   = r_rx_ovf;
    w_status[ST_TX_BUSY]  = w_tx_busy;
  end

  always_comb begin
    w_rd_val = '0;
    if (w_is_div_lo)      w_rd_val = D_W'(r_div[7:0]);
    else if (w_is_div_hi) w_rd_val = D_W'(r_div[15:8]);
    else if (w_is_status) w_rd_val = w_status;
    else if (w_is_ctrl)   w_rd_val = D_W'(r_ctrl);
  end

  // Side effects are committed on the edge into RESP so they are visible in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_div      <= 16'(DIV_RST);
      r_ctrl     <= '0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= '0;
      r_tx_wr_en <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_pready   <= 1'b0;
      r_tx_wr_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (PSEL && !PENABLE) begin
            r_state <= StDecode;
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
          end
        end
        StDecode: begin
          if (w_pop) begin
            r_state <= StFetch;
          end else begin
            r_state   <= StResp;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= (r_write || w_err) ? '0 : w_rd_val;
            if (w_do_write) begin
              if (w_is_data) begin
                r_tx_wr_en <= 1'b1;
                r_tx_data  <= r_wdata;
              end else if (w_is_div_lo) begin
                r_div[7:0] <= r_wdata[7:0];
              end else if (w_is_div_hi) begin
                r_div[15:8] <= r_wdata[7:0];
              end else if (w_is_ctrl) begin
                r_ctrl <= r_wdata[2:0];
              end
            end
          end
        end
        StFetch: begin
          r_state   <= StResp;
          r_pready  <= 1'b1;
          r_pslverr <= 1'b0;
          r_prdata  <= rx_ff_data;
        end
        StResp: begin
          r_state   <= StIdle;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // A fresh overflow outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ovf <= 1'b0;
    end else if (rx_ff_wr_en && rx_ff_full) begin
      r_rx_ovf <= 1'b1;
    end else if (w_clr_ovf) begin
      r_rx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_ctrl[CTRL_RX_IE] && !rx_ff_empty) ||
               (r_ctrl[CTRL_TX_IE] && tx_ff_empty && !w_tx_busy) || r_rx_ovf;
    end
  end

  uart_tx_sched u_tx_sched (
    .clk        (clk),
    .rst        (rst),
    .i_tx_en    (r_ctrl[CTRL_TX_EN]),
    .i_ff_empty (tx_ff_empty),
    .i_tx_done  (tx_done),
    .o_tx_start (tx_start),
    .o_tx_busy  (w_tx_busy)
  );

  assign PREADY      = r_pready;
  assign PSLVERR     = r_pslverr;
  assign PRDATA      = r_prdata;
  assign rx_ff_rd_en = w_pop;
  assign tx_ff_wr_en = r_tx_wr_en;
  assign tx_ff_data  = r_tx_data;
  assign divxr       = DIV_W'(r_div);
  assign irq         = r_irq;

endmodule
